priv_trap_reporter: RTL and testbench
=====================================

// Module: priv_trap_reporter
// PURPOSE
//  Pipeline-side end of the privileged-unit interface. Collects mem-stage exceptions, xRET and pending-interrupt
//  events, reports one prioritised trap per event to the priv unit (one-hot fault flag, epc, badaddr, pipe_clear),
//  waits for the priv unit's insert_pc/priv_pc response, then issues a single fetch redirect and a timed pipeline flush.
// PARAMETERS
//  WORD_SIZE     32   address/data width
//  FLUSH_CYCLES  2    cycles flush held high after redirect (>=1)
//  RESP_TIMEOUT  15   max cycles in WAIT before the error path is taken (4-bit counter)
// PORTS
//  CLK               in   1          clock, rising edge
//  RST               in   1          synchronous reset, active-high
//  mem_valid         in   1          valid instruction in mem stage
//  mem_pc            in   WORD_SIZE  pc of mem-stage instruction
//  mem_badaddr       in   WORD_SIZE  faulting address / instruction bits
//  mem_exc           in   13         raw flags [12:0]: brk,ipf,iaf,mal_i,ill,env,mal_l,mal_s,lpf,spf,laf,saf,rsvd(0)
//  mem_mret/mem_sret in   1          xRET instruction in mem stage
//  intr              in   1          pending interrupt from priv unit
//  insert_pc         in   1          priv unit response: priv_pc valid
//  priv_pc           in   WORD_SIZE  trap vector / xepc target
//  fault_o           out  12         one-hot reported exception, same bit order as mem_exc[12:1]
//  mret_o/sret_o     out  1          one-cycle xRET pulse to priv unit
//  epc               out  WORD_SIZE  latched mem_pc
//  badaddr           out  WORD_SIZE  latched mem_badaddr (0 for interrupts/xRET)
//  pipe_clear        out  1          pipeline drained, trap may commit
//  mem_stall         out  1          freeze mem stage and upstream
//  redirect_valid    out  1          one-cycle fetch redirect
//  redirect_pc       out  WORD_SIZE  target for redirect
//  flush             out  1          kill all stages younger than WB
//  resp_err          out  1          sticky: priv unit did not respond within RESP_TIMEOUT
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters 0; resp_err cleared. Reset mid-operation aborts any trap, no redirect.
//  FSM IDLE -> REPORT -> WAIT -> FLUSH -> IDLE.
//  IDLE: event = mem_valid & (|mem_exc[12:1] | mem_mret | mem_sret | intr). On event: latch epc=mem_pc, badaddr,
//   priority-select exception, assert mem_stall combinationally the same cycle; -> REPORT. No event: outputs 0.
//  Priority (high->low): brk, ipf, iaf, mal_i, ill, env, mal_l, mal_s, lpf, spf, laf, saf; exception beats xRET beats
//   intr. Only the winner is reported; others dropped (instruction re-executes after trap return if needed).
//  intr with no exception: fault_o=0, badaddr=0, epc=mem_pc (instruction not committed).
//  REPORT (exactly 1 cycle): drive fault_o or mret_o/sret_o, pipe_clear=1, mem_stall=1; -> WAIT.
//  WAIT: mem_stall=1, fault_o/mret_o/sret_o=0, epc held. insert_pc may arrive in REPORT or any WAIT cycle;
//   insert_pc in REPORT is captured and WAIT is skipped (-> FLUSH next). On insert_pc: latch priv_pc, -> FLUSH.
//   Timeout counter counts WAIT cycles; at RESP_TIMEOUT: set resp_err, redirect to latched epc, -> FLUSH.
//  FLUSH: first cycle redirect_valid=1, redirect_pc=latched target; flush=1 for FLUSH_CYCLES cycles, mem_stall=0;
//   -> IDLE. Events arriving during REPORT/WAIT/FLUSH are ignored (mem stage is stalled/flushed).
//  insert_pc asserted in IDLE or FLUSH is ignored. Back-to-back trap allowed on first IDLE cycle after FLUSH.
//  resp_err cleared only by RST.
// TESTING
//  illegal at pc 0x100, badaddr 0x0000DEAD, insert_pc 3 cycles later with priv_pc 0x8000_0004 -> fault_o[ill] 1 cycle,
//   epc=0x100, badaddr=0xDEAD, redirect_pc=0x8000_0004 one cycle, flush 2 cycles, back in IDLE 7 cycles after event.
//  mem_exc brk+mal_l+laf together -> only fault_o[brk] pulses; others never seen.
//  mret with intr high, insert_pc in REPORT cycle -> mret_o pulse, WAIT skipped, redirect next cycle.
//  intr alone at pc 0x200 -> fault_o=0, epc=0x200, badaddr=0, redirect to priv_pc.
//  no insert_pc for 15 WAIT cycles -> resp_err=1, redirect_pc=epc, FSM returns to IDLE.
//  RST asserted in WAIT -> next cycle all outputs 0, no redirect_valid, resp_err 0.

Source files
------------

// File: rtl/priv_trap_reporter.sv
// priv_trap_reporter: reports one prioritised trap per mem-stage event to the priv unit, then redirects and flushes.
module priv_trap_reporter #(
  parameter int WORD_SIZE    = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int RESP_TIMEOUT = 15
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 mem_valid,
  input  logic [WORD_SIZE-1:0] mem_pc,
  input  logic [WORD_SIZE-1:0] mem_badaddr,
  input  logic [12:0]          mem_exc,
  input  logic                 mem_mret,
  input  logic                 mem_sret,
  input  logic                 intr,
  input  logic                 insert_pc,
  input  logic [WORD_SIZE-1:0] priv_pc,
  output logic [11:0]          fault_o,
  output logic                 mret_o,
  output logic                 sret_o,
  output logic [WORD_SIZE-1:0] epc,
  output logic [WORD_SIZE-1:0] badaddr,
  output logic                 pipe_clear,
  output logic                 mem_stall,
  output logic                 redirect_valid,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 flush,
  output logic                 resp_err
);
  typedef enum logic [1:0] {IDLE, REPORT, WAIT, FLUSH} state_t;
  state_t state_q, state_d;
  logic [WORD_SIZE-1:0] epc_q, epc_d, bad_q, bad_d, tgt_q, tgt_d;
  logic [11:0] fault_q, fault_d, sel;
  logic mret_q, mret_d, sret_q, sret_d, err_q, err_d, exc, evt;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic unused_rsvd;
  assign unused_rsvd = mem_exc[0];
  assign exc = |mem_exc[12:1];
  assign evt = mem_valid & (exc | mem_mret | mem_sret | intr);
  // Ascending scan so the highest-numbered flag (brk) wins
  always_comb begin
    sel = '0;
    for (int i = 1; i < 13; i++)
      if (mem_exc[i]) begin
        sel = '0;
        sel[i-1] = 1'b1;
      end
  end
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    bad_d   = bad_q;
    tgt_d   = tgt_q;
    fault_d = fault_q;
    mret_d  = mret_q;
    sret_d  = sret_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: if (evt) begin
        state_d = REPORT;
        epc_d   = mem_pc;
        bad_d   = exc ? mem_badaddr : '0;
        fault_d = sel;
        mret_d  = !exc && mem_mret;
        sret_d  = !exc && !mem_mret && mem_sret;
      end
      REPORT: begin
        cnt_d   = '0;
        fcnt_d  = '0;
        tgt_d   = insert_pc ? priv_pc : tgt_q;
        state_d = insert_pc ? FLUSH : WAIT;
      end
      WAIT: if (insert_pc) begin
        tgt_d   = priv_pc;
        state_d = FLUSH;
      end else if (cnt_q == 4'(RESP_TIMEOUT - 1)) begin
        err_d   = 1'b1;
        tgt_d   = epc_q;
        state_d = FLUSH;
      end else cnt_d = cnt_q + 4'd1;
      FLUSH: if (fcnt_q == 8'(FLUSH_CYCLES - 1)) state_d = IDLE;
             else fcnt_d = fcnt_q + 8'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      epc_q   <= '0;
      bad_q   <= '0;
      tgt_q   <= '0;
      fault_q <= '0;
      mret_q  <= 1'b0;
      sret_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      bad_q   <= bad_d;
      tgt_q   <= tgt_d;
      fault_q <= fault_d;
      mret_q  <= mret_d;
      sret_q  <= sret_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
    end
  end
  always_comb begin
    fault_o        = state_q == REPORT ? fault_q : '0;
    mret_o         = state_q == REPORT && mret_q;
    sret_o         = state_q == REPORT && sret_q;
    pipe_clear     = state_q == REPORT;
    epc            = state_q != IDLE ? epc_q : '0;
    badaddr        = state_q != IDLE ? bad_q : '0;
    mem_stall      = (state_q == IDLE && evt) || state_q == REPORT || state_q == WAIT;
    redirect_valid = state_q == FLUSH && fcnt_q == '0;
    redirect_pc    = redirect_valid ? tgt_q : '0;
    flush          = state_q == FLUSH;
    resp_err       = err_q;
  end
endmodule

// File: tb/tb_priv_trap_reporter.sv
// tb_priv_trap_reporter: directed scenarios for the trap reporter with hand-computed expectations.
module tb_priv_trap_reporter;
  logic CLK = 0, RST = 1, mem_valid = 0, mem_mret = 0, mem_sret = 0, intr = 0, insert_pc = 0;
  logic [31:0] mem_pc = 0, mem_badaddr = 0, priv_pc = 0;
  logic [12:0] mem_exc = 0;
  logic [11:0] fault_o;
  logic mret_o, sret_o, pipe_clear, mem_stall, redirect_valid, flush, resp_err;
  logic [31:0] epc, badaddr, redirect_pc;
  int tests = 0, fails = 0;
  int n_fault, n_mret, n_sret, n_clear, n_redir, n_flush, redir_cyc, mret_cyc, err_cyc;
  logic [11:0] fault_seen;
  logic [31:0] epc_rep, bad_rep, redir_pc, epc_w;
  logic stall_evt, idle_ok;

  priv_trap_reporter dut (
    .CLK(CLK), .RST(RST), .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_badaddr(mem_badaddr),
    .mem_exc(mem_exc), .mem_mret(mem_mret), .mem_sret(mem_sret), .intr(intr), .insert_pc(insert_pc),
    .priv_pc(priv_pc), .fault_o(fault_o), .mret_o(mret_o), .sret_o(sret_o), .epc(epc), .badaddr(badaddr),
    .pipe_clear(pipe_clear), .mem_stall(mem_stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .resp_err(resp_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  // Cycle 0 presents the event; cycles 1..ncyc are observed; insert_pc pulses on cycle ins_at.
  task automatic run(input logic [12:0] exc, input logic mr, sr, it, input logic [31:0] pc, bad, tgt,
                     input int ins_at, hold, ncyc);
    n_fault = 0; n_mret = 0; n_sret = 0; n_clear = 0; n_redir = 0; n_flush = 0;
    redir_cyc = -1; mret_cyc = -1; err_cyc = -1; fault_seen = 0; epc_rep = 0; bad_rep = 0; redir_pc = 0; epc_w = 0;
    cyc();
    mem_valid = 1; mem_exc = exc; mem_mret = mr; mem_sret = sr; intr = it;
    mem_pc = pc; mem_badaddr = bad; priv_pc = tgt; insert_pc = 0;
    #1 stall_evt = mem_stall;
    for (int c = 1; c <= ncyc; c++) begin
      cyc();
      if (c > hold) begin mem_valid = 0; mem_exc = 0; mem_mret = 0; mem_sret = 0; intr = 0; end
      insert_pc = (c == ins_at);
      #1;
      if (fault_o != 0) begin n_fault++; fault_seen |= fault_o; end
      if (mret_o) begin n_mret++; mret_cyc = c; end
      if (sret_o) n_sret++;
      if (pipe_clear) begin n_clear++; epc_rep = epc; bad_rep = badaddr; end
      if (redirect_valid) begin n_redir++; redir_cyc = c; redir_pc = redirect_pc; end
      if (flush) n_flush++;
      if (resp_err && err_cyc < 0) err_cyc = c;
      if (c == 3) epc_w = epc;
    end
    idle_ok = !mem_stall && !flush && !redirect_valid && !pipe_clear && fault_o == 0 && !mret_o && !sret_o
              && epc == 0 && badaddr == 0 && redirect_pc == 0;
    insert_pc = 0; mem_valid = 0; mem_exc = 0; mem_mret = 0; mem_sret = 0; intr = 0;
  endtask

  task automatic test_reset();
    RST = 1;
    repeat (3) cyc();
    #1;
    tests++; if ({fault_o, mret_o, sret_o, pipe_clear, mem_stall, redirect_valid, flush, resp_err} !== '0) begin fails++; $display("FAIL reset_ctrl: got %b required 0", {fault_o, mret_o, sret_o, pipe_clear, mem_stall, redirect_valid, flush, resp_err}); end
    tests++; if ({epc, badaddr, redirect_pc} !== '0) begin fails++; $display("FAIL reset_data: got %h required 0", {epc, badaddr, redirect_pc}); end
    RST = 0;
    cyc(); #1;
    tests++; if ({mem_stall, flush, redirect_valid, resp_err} !== 4'b0) begin fails++; $display("FAIL reset_idle: got %b required 0000", {mem_stall, flush, redirect_valid, resp_err}); end
  endtask

  task automatic test_illegal();
    run(13'h0100, 0, 0, 0, 32'h100, 32'h0000DEAD, 32'h8000_0004, 4, 0, 7);
    tests++; if (stall_evt !== 1'b1) begin fails++; $display("FAIL ill_stall: got %b required 1", stall_evt); end
    tests++; if (n_fault !== 1 || fault_seen !== 12'h080) begin fails++; $display("FAIL ill_fault: got %0d x %h required 1 x 080", n_fault, fault_seen); end
    tests++; if (n_clear !== 1) begin fails++; $display("FAIL ill_pipe_clear: got %0d required 1", n_clear); end
    tests++; if (epc_rep !== 32'h100 || epc_w !== 32'h100) begin fails++; $display("FAIL ill_epc: got %h/%h required 100", epc_rep, epc_w); end
    tests++; if (bad_rep !== 32'hDEAD) begin fails++; $display("FAIL ill_badaddr: got %h required 0000dead", bad_rep); end
    tests++; if (n_redir !== 1 || redir_cyc !== 5 || redir_pc !== 32'h8000_0004) begin fails++; $display("FAIL ill_redirect: got n=%0d cyc=%0d pc=%h required 1/5/80000004", n_redir, redir_cyc, redir_pc); end
    tests++; if (n_flush !== 2) begin fails++; $display("FAIL ill_flush: got %0d required 2", n_flush); end
    tests++; if (idle_ok !== 1'b1) begin fails++; $display("FAIL ill_idle_at7: got %b required 1", idle_ok); end
    tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL ill_resp_err: got %b required 0", resp_err); end
  endtask

  task automatic test_priority();
    run(13'h1044, 0, 0, 1, 32'h140, 32'h55, 32'h8000_0010, 2, 3, 5);
    tests++; if (n_fault !== 1 || fault_seen !== 12'h800) begin fails++; $display("FAIL prio_brk: got %0d x %h required 1 x 800", n_fault, fault_seen); end
    tests++; if (n_redir !== 1 || redir_pc !== 32'h8000_0010) begin fails++; $display("FAIL prio_redirect: got %0d %h required 1 80000010", n_redir, redir_pc); end
    tests++; if (idle_ok !== 1'b1) begin fails++; $display("FAIL prio_idle: got %b required 1", idle_ok); end
  endtask

  task automatic test_xret();
    run(13'h0, 1, 0, 1, 32'h180, 32'h77, 32'h0000_4000, 1, 0, 4);
    tests++; if (n_mret !== 1 || mret_cyc !== 1 || n_sret !== 0) begin fails++; $display("FAIL xret_pulse: got n=%0d cyc=%0d sret=%0d required 1/1/0", n_mret, mret_cyc, n_sret); end
    tests++; if (n_fault !== 0 || bad_rep !== 0) begin fails++; $display("FAIL xret_fault: got %0d bad=%h required 0 0", n_fault, bad_rep); end
    tests++; if (redir_cyc !== 2 || redir_pc !== 32'h4000) begin fails++; $display("FAIL xret_skip_wait: got cyc=%0d pc=%h required 2 00004000", redir_cyc, redir_pc); end
    tests++; if (idle_ok !== 1'b1) begin fails++; $display("FAIL xret_idle: got %b required 1", idle_ok); end
    run(13'h0, 0, 1, 0, 32'h1C0, 32'h0, 32'h0000_5000, 2, 0, 5);
    tests++; if (n_sret !== 1 || n_mret !== 0 || redir_pc !== 32'h5000) begin fails++; $display("FAIL sret_pulse: got %0d/%0d pc=%h required 1/0 00005000", n_sret, n_mret, redir_pc); end
  endtask

  task automatic test_intr();
    run(13'h0, 0, 0, 1, 32'h200, 32'h1234, 32'h8000_0100, 3, 0, 6);
    tests++; if (n_fault !== 0 || n_mret !== 0 || n_sret !== 0) begin fails++; $display("FAIL intr_nofault: got %0d/%0d/%0d required 0/0/0", n_fault, n_mret, n_sret); end
    tests++; if (epc_rep !== 32'h200 || bad_rep !== 0) begin fails++; $display("FAIL intr_epc_bad: got %h %h required 200 0", epc_rep, bad_rep); end
    tests++; if (n_redir !== 1 || redir_pc !== 32'h8000_0100) begin fails++; $display("FAIL intr_redirect: got %0d %h required 1 80000100", n_redir, redir_pc); end
  endtask

  task automatic test_timeout();
    run(13'h0002, 0, 0, 0, 32'h300, 32'hBEEF, 32'hFFFF_FFFF, -1, 0, 19);
    tests++; if (err_cyc !== 17 || resp_err !== 1'b1) begin fails++; $display("FAIL tmo_resp_err: got cyc=%0d err=%b required 17 1", err_cyc, resp_err); end
    tests++; if (n_redir !== 1 || redir_cyc !== 17 || redir_pc !== 32'h300) begin fails++; $display("FAIL tmo_redirect: got n=%0d cyc=%0d pc=%h required 1/17/300", n_redir, redir_cyc, redir_pc); end
    tests++; if (n_flush !== 2 || idle_ok !== 1'b1) begin fails++; $display("FAIL tmo_idle: got flush=%0d idle=%b required 2 1", n_flush, idle_ok); end
  endtask

  task automatic test_back_to_back();
    run(13'h0100, 0, 0, 0, 32'h400, 32'h1, 32'h9000_0000, 2, 0, 4);
    tests++; if (redir_cyc !== 3 || n_flush !== 2) begin fails++; $display("FAIL b2b_first: got cyc=%0d flush=%0d required 3 2", redir_cyc, n_flush); end
    run(13'h0080, 0, 0, 0, 32'h404, 32'h2, 32'h9000_0040, 2, 0, 5);
    tests++; if (stall_evt !== 1'b1) begin fails++; $display("FAIL b2b_accept: got %b required 1", stall_evt); end
    tests++; if (fault_seen !== 12'h040 || epc_rep !== 32'h404) begin fails++; $display("FAIL b2b_env: got %h %h required 040 404", fault_seen, epc_rep); end
    tests++; if (resp_err !== 1'b1) begin fails++; $display("FAIL b2b_sticky_err: got %b required 1", resp_err); end
  endtask

  task automatic test_reset_wait();
    int seen;
    cyc();
    mem_valid = 1; mem_exc = 13'h0100; mem_pc = 32'h500; mem_badaddr = 32'h9; priv_pc = 32'hA000_0000;
    cyc();
    mem_valid = 0; mem_exc = 0;
    cyc(); #1;
    tests++; if (mem_stall !== 1'b1 || pipe_clear !== 1'b0) begin fails++; $display("FAIL rstw_in_wait: got stall=%b clr=%b required 1 0", mem_stall, pipe_clear); end
    RST = 1;
    cyc();
    RST = 0; insert_pc = 1;
    #1;
    tests++; if ({fault_o, mret_o, sret_o, pipe_clear, mem_stall, redirect_valid, flush, resp_err} !== '0 || {epc, badaddr, redirect_pc} !== '0) begin fails++; $display("FAIL rstw_outputs: got %b %h required 0", {fault_o, pipe_clear, mem_stall, redirect_valid, flush, resp_err}, {epc, badaddr, redirect_pc}); end
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      cyc(); #1;
      if (redirect_valid || flush || mem_stall) seen++;
    end
    insert_pc = 0;
    tests++; if (seen !== 0) begin fails++; $display("FAIL rstw_no_redirect: got %0d active cycles required 0", seen); end
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_priority();
    test_xret();
    test_intr();
    test_timeout();
    test_back_to_back();
    test_reset_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
